// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg                                                             |
// | Shared UART definitions: state encoding, baud divider and width      |
// | helpers for the transmit and receive framers.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

  // Frame sequencing states, shared by the TX and RX framers.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Number of bits needed to hold values 0..value-1.
  function automatic int uart_clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  // Clocks per serial bit.
  function automatic int uart_baud_cnt_max(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_frame_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_frame_if                                                     |
// | Valid/ready word handshake into the UART transmitter.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] pi_data;
  logic                 pi_valid;
  logic                 pi_ready;

  modport master (output pi_data, output pi_valid, input pi_ready);
  modport slave  (input pi_data, input pi_valid, output pi_ready);
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_baud_gen                                                        |
// | Bit-period counter: counts 0..BAUD_CNT_MAX-1 while enabled, held at |
// | zero while disabled, bit_end flags the last clock of each bit.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BAUD_CNT_MAX = 10,
  parameter int CNT_W        = uart_clog2(BAUD_CNT_MAX)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             bit_end
);

  assign bit_end = enable && (count == CNT_W'(BAUD_CNT_MAX - 1));

  // Free-running bit-period counter, restarted at each bit boundary.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count <= '0;
    end else if (!enable || bit_end) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_frame                                                        |
// | Parametrised UART transmitter: start bit, DATA_BITS data bits LSB   |
// | first, optional parity, STOP_BITS stop bits. Valid/ready input,     |
// | busy/done status. Parity is compiled in with UART_TX_PARITY_EN.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int UART_BPS   = 9600,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  uart_tx_frame_if.slave pi,
  output logic           tx,
  output logic           tx_busy,
  output logic           tx_done
);

  localparam int BAUD_CNT_MAX = uart_baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int CNT_W        = uart_clog2(BAUD_CNT_MAX);
  // Wide enough for the data bit index; stop-bit index (0..1) always fits.
  localparam int BIT_W        = uart_clog2(DATA_BITS + 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      BAUD_CNT_MAX < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_frame: illegal parameter combination");
  end

  uart_state_t          state;
  logic [DATA_BITS-1:0] shreg;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 ready;
  logic [CNT_W-1:0]     count;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  uart_baud_gen #(
    .BAUD_CNT_MAX (BAUD_CNT_MAX),
    .CNT_W        (CNT_W)
  ) u_baud (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .enable    (state != IDLE),
    .count     (count),
    .bit_end   (bit_end)
  );

  assign pi.pi_ready = ready;
  assign tx_busy     = !ready;
  // Last clock of the last stop bit.
  assign tx_done     = (state == STOP) && (count == CNT_W'(BAUD_CNT_MAX - 1)) &&
                       (bit_cnt == BIT_W'(STOP_BITS - 1));

  // Frame sequencer; tx is loaded on the same edge as the state it belongs to.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      ready   <= 1'b1;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pi.pi_valid) begin
            shreg   <= pi.pi_data;
            bit_cnt <= '0;
            ready   <= 1'b0;
            tx      <= 1'b0;
            state   <= START;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^pi.pi_data) ^ 1'(PARITY_ODD);
`endif
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            bit_cnt <= '0;
            tx      <= 1'b1;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              ready   <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          bit_cnt <= '0;
          ready   <= 1'b1;
          tx      <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_uart_tx_frame                                                     |
// | Bench for uart_tx_frame: an 8N1 instance and a 7-data/2-stop odd-   |
// | parity instance, checked cycle by cycle against a frame model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_tx_frame;

  localparam int BAUD = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
  uart_tx_frame_if #(.DATA_BITS(7)) if1 ();
  logic tx0, busy0, done0, tx1, busy1, done1;

  uart_tx_frame #(.UART_BPS(5_000_000), .CLK_FREQ(50_000_000), .DATA_BITS(8),
                  .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .pi(if0.slave),
    .tx(tx0), .tx_busy(busy0), .tx_done(done0));

  uart_tx_frame #(.UART_BPS(5_000_000), .CLK_FREQ(50_000_000), .DATA_BITS(7),
                  .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .pi(if1.slave),
    .tx(tx1), .tx_busy(busy1), .tx_done(done1));

  int n_checks = 0;
  int n_fail   = 0;
  int exp_len;
  logic exp_tx[0:255], exp_done[0:255], exp_ready[0:255];
  logic obs_tx[0:255], obs_done[0:255], obs_ready[0:255], obs_busy[0:255];

  // Reference: list of frame bits, each stretched to BAUD clocks, then one idle cycle.
  task automatic model_frame(input logic [8:0] data, input int nbits, input int nstop, input int odd);
    logic bits[$];
    int ones;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      bits.push_back(data[i]);
      if (data[i]) ones++;
    end
    if (P == 1) bits.push_back(((ones % 2) ^ odd) != 0);
    for (int i = 0; i < nstop; i++) bits.push_back(1'b1);
    exp_len = bits.size() * BAUD;
    for (int k = 0; k < exp_len; k++) begin
      exp_tx[k]    = bits[k / BAUD];
      exp_done[k]  = (k == exp_len - 1);
      exp_ready[k] = 1'b0;
    end
    exp_tx[exp_len]    = 1'b1;
    exp_done[exp_len]  = 1'b0;
    exp_ready[exp_len] = 1'b1;
  endtask

  task automatic drive(input int which, input logic [8:0] d, input logic v);
    if (which == 0) begin
      if0.pi_data = d[7:0]; if0.pi_valid = v;
    end else begin
      if1.pi_data = d[6:0]; if1.pi_valid = v;
    end
  endtask

  // Waits for the accept edge, then samples len+1 cycles at the falling edge.
  task automatic capture(input int which, input int len, input bit drop);
    @(posedge clk);
    if (drop) begin
      #1;
      if (which == 0) if0.pi_valid = 1'b0; else if1.pi_valid = 1'b0;
    end
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      obs_tx[k]    = (which == 0) ? tx0    : tx1;
      obs_done[k]  = (which == 0) ? done0  : done1;
      obs_ready[k] = (which == 0) ? if0.pi_ready : if1.pi_ready;
      obs_busy[k]  = (which == 0) ? busy0  : busy1;
    end
  endtask

  task automatic test_reset();
    drive(0, 9'h0, 1'b0);
    drive(1, 9'h0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx0, if0.pi_ready, busy0, done0} !== 4'b1100) begin
      n_fail++; $display("FAIL reset dut0: tx/ready/busy/done=%b required 1100", {tx0, if0.pi_ready, busy0, done0});
    end
    n_checks++;
    if ({tx1, if1.pi_ready, busy1, done1} !== 4'b1100) begin
      n_fail++; $display("FAIL reset dut1: tx/ready/busy/done=%b required 1100", {tx1, if1.pi_ready, busy1, done1});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1();
    int low_cnt, done_at;
    drive(0, 9'h55, 1'b1);
    model_frame(9'h55, 8, 1, 0);
    capture(0, exp_len, 1'b1);
    low_cnt = 0; done_at = -1;
    for (int k = 0; k <= exp_len; k++) begin
      n_checks++;
      if (obs_tx[k] !== exp_tx[k] || obs_done[k] !== exp_done[k] ||
          obs_ready[k] !== exp_ready[k] || obs_busy[k] !== !exp_ready[k]) begin
        n_fail++; $display("FAIL 8n1 cycle %0d: tx/done/ready/busy=%b%b%b%b required %b%b%b%b", k,
                           obs_tx[k], obs_done[k], obs_ready[k], obs_busy[k],
                           exp_tx[k], exp_done[k], exp_ready[k], !exp_ready[k]);
      end
      if (obs_ready[k] === 1'b0) low_cnt++;
      if (obs_done[k] === 1'b1) done_at = k;
    end
    n_checks++;
    if (low_cnt != (10 + P) * BAUD) begin
      n_fail++; $display("FAIL 8n1 ready_low: %0d clocks, required %0d", low_cnt, (10 + P) * BAUD);
    end
    n_checks++;
    if (done_at != (10 + P) * BAUD - 1) begin
      n_fail++; $display("FAIL 8n1 done_pos: clock %0d, required %0d", done_at + 1, (10 + P) * BAUD);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] words [2];
    words[0] = 9'h0A3; words[1] = 9'h00F;
    drive(0, words[0], 1'b1);
    for (int f = 0; f < 2; f++) begin
      model_frame(words[f], 8, 1, 0);
      fork
        capture(0, exp_len, f == 1);
        begin
          repeat (5) @(negedge clk);
          if0.pi_data = words[1][7:0];
        end
      join
      for (int k = 0; k <= exp_len; k++) begin
        n_checks++;
        if (obs_tx[k] !== exp_tx[k] || obs_done[k] !== exp_done[k] || obs_ready[k] !== exp_ready[k]) begin
          n_fail++; $display("FAIL b2b frame %0d cycle %0d: tx/done/ready=%b%b%b required %b%b%b", f, k,
                             obs_tx[k], obs_done[k], obs_ready[k], exp_tx[k], exp_done[k], exp_ready[k]);
        end
      end
    end
  endtask

  task automatic test_data_hold();
    int low_cnt;
    drive(0, 9'h012, 1'b1);
    model_frame(9'h012, 8, 1, 0);
    fork
      capture(0, exp_len, 1'b1);
      begin
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 if0.pi_data = 8'hFF;
        repeat (30) @(negedge clk);
        if0.pi_valid = 1'b1;
        @(negedge clk);
        if0.pi_valid = 1'b0;
      end
    join
    for (int k = 0; k <= exp_len; k++) begin
      n_checks++;
      if (obs_tx[k] !== exp_tx[k] || obs_done[k] !== exp_done[k] || obs_ready[k] !== exp_ready[k]) begin
        n_fail++; $display("FAIL hold cycle %0d: tx/done/ready=%b%b%b required %b%b%b", k,
                           obs_tx[k], obs_done[k], obs_ready[k], exp_tx[k], exp_done[k], exp_ready[k]);
      end
    end
    low_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || if0.pi_ready !== 1'b1) low_cnt++;
    end
    n_checks++;
    if (low_cnt != 0) begin
      n_fail++; $display("FAIL extra_frame: %0d non-idle clocks after frame, required 0", low_cnt);
    end
  endtask

  task automatic test_7d2s();
    int low_cnt;
    drive(1, 9'h07F, 1'b1);
    model_frame(9'h07F, 7, 2, 1);
    capture(1, exp_len, 1'b1);
    low_cnt = 0;
    for (int k = 0; k <= exp_len; k++) begin
      n_checks++;
      if (obs_tx[k] !== exp_tx[k] || obs_done[k] !== exp_done[k] || obs_ready[k] !== exp_ready[k]) begin
        n_fail++; $display("FAIL 7d2s cycle %0d: tx/done/ready=%b%b%b required %b%b%b", k,
                           obs_tx[k], obs_done[k], obs_ready[k], exp_tx[k], exp_done[k], exp_ready[k]);
      end
      if (obs_ready[k] === 1'b0) low_cnt++;
    end
    n_checks++;
    if (low_cnt != (10 + P) * BAUD) begin
      n_fail++; $display("FAIL 7d2s length: %0d clocks, required %0d", low_cnt, (10 + P) * BAUD);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [8:0] words [2];
    logic       par_even [2];
    int         bad;
    words[0] = 9'h007; par_even[0] = 1'b1;
    words[1] = 9'h003; par_even[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 2; i++) begin
        drive(d, words[i], 1'b1);
        model_frame(words[i], (d == 0) ? 8 : 7, (d == 0) ? 1 : 2, d);
        capture(d, exp_len, 1'b1);
        bad = 0;
        for (int k = 0; k <= exp_len; k++) begin
          if (obs_tx[k] !== exp_tx[k] || obs_done[k] !== exp_done[k] || obs_ready[k] !== exp_ready[k]) bad++;
        end
        n_checks++;
        if (bad != 0) begin
          n_fail++; $display("FAIL parity frame dut%0d word %h: %0d bad clocks, required 0", d, words[i], bad);
        end
        bad = 0;
        for (int k = 0; k < BAUD; k++) begin
          if (obs_tx[((d == 0) ? 9 : 8) * BAUD + k] !== (par_even[i] ^ (d == 1))) bad++;
        end
        n_checks++;
        if (bad != 0) begin
          n_fail++; $display("FAIL parity_bit dut%0d word %h: %0d wrong clocks, required bit %b", d, words[i], bad,
                             par_even[i] ^ (d == 1));
        end
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [8:0] d;
    int bad;
    d = 9'($urandom_range(0, 255));
    drive(0, d, 1'b1);
    @(posedge clk);
    #1 if0.pi_valid = 1'b0;
    repeat (45) @(negedge clk);
    n_checks++;
    if (tx0 !== d[3]) begin
      n_fail++; $display("FAIL pre_reset bit3: tx=%b required %b", tx0, d[3]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx0, busy0, if0.pi_ready} !== 3'b101) begin
      n_fail++; $display("FAIL async_reset: tx/busy/ready=%b required 101", {tx0, busy0, if0.pi_ready});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || if0.pi_ready !== 1'b1 || done0 !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL post_reset_idle: %0d non-idle clocks, required 0", bad);
    end
    drive(0, 9'h03C, 1'b1);
    model_frame(9'h03C, 8, 1, 0);
    capture(0, exp_len, 1'b1);
    for (int k = 0; k <= exp_len; k++) begin
      n_checks++;
      if (obs_tx[k] !== exp_tx[k] || obs_done[k] !== exp_done[k] || obs_ready[k] !== exp_ready[k]) begin
        n_fail++; $display("FAIL after_reset cycle %0d: tx/done/ready=%b%b%b required %b%b%b", k,
                           obs_tx[k], obs_done[k], obs_ready[k], exp_tx[k], exp_done[k], exp_ready[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] d;
    int which, bad;
    for (int i = 0; i < 8; i++) begin
      which = i % 2;
      d = 9'($urandom);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      drive(which, d, 1'b1);
      model_frame(d, (which == 0) ? 8 : 7, (which == 0) ? 1 : 2, which);
      capture(which, exp_len, 1'b1);
      bad = 0;
      for (int k = 0; k <= exp_len; k++) begin
        if (obs_tx[k] !== exp_tx[k] || obs_done[k] !== exp_done[k] || obs_ready[k] !== exp_ready[k]) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL random frame %0d dut%0d data %h: %0d bad clocks, required 0", i, which, d, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_back_to_back();
    test_data_hold();
    test_7d2s();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
